// File: rtl/viterbi_pkg.sv
// Shared constants, types and code helpers for the rate-1/2, K=3 hard-decision Viterbi decoder.
// The optional best_metric output is enabled with the VITERBI_PM_OUT_EN macro.
package viterbi_pkg;

   localparam int NUM_STATES = 4;
   localparam int NUM_STEPS  = 8;
   localparam int PM_W       = 6;
   localparam int IN_W       = 2 * NUM_STEPS;

   localparam logic [PM_W-1:0] PM_INF = 6'd32;

   // Generator taps over the register {u_t, u_{t-1}, u_{t-2}}
   localparam logic [2:0] G0 = 3'b100;
   localparam logic [2:0] G1 = 3'b111;

   typedef logic [1:0]            state_t;
   typedef logic [PM_W-1:0]       pm_t;
   typedef logic [NUM_STATES-1:0] surv_t;

   function automatic logic [1:0] branch_out(input logic u, input state_t s);
      logic [2:0] r;
      r = {u, s};
      return {^(r & G0), ^(r & G1)};
   endfunction

   function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] d;
      d = a ^ b;
      return {1'b0, d[1]} + {1'b0, d[0]};
   endfunction

endpackage

// File: rtl/viterbi_if.sv
// Block-level bus of the Viterbi decoder: received block in, decoded bits (and optional
// winning metric when VITERBI_PM_OUT_EN is defined) out.
interface viterbi_if;
   import viterbi_pkg::*;

   logic [IN_W-1:0]      data_in;
   logic [NUM_STEPS-1:0] data_out;
`ifdef VITERBI_PM_OUT_EN
   logic [PM_W-1:0]      best_metric;

   modport master (output data_in, input data_out, input best_metric);
   modport slave  (input data_in, output data_out, output best_metric);
`else
   modport master (output data_in, input data_out);
   modport slave  (input data_in, output data_out);
`endif

endinterface

// File: rtl/viterbi_acs.sv
// One add-compare-select cell: picks the cheaper of two predecessor paths, ties go to pred {a,0}.
module viterbi_acs
   import viterbi_pkg::*;
(
   input  pm_t        pm0,
   input  pm_t        pm1,
   input  logic [1:0] bm0,
   input  logic [1:0] bm1,
   output pm_t        pm_new,
   output logic       dec
);

   pm_t cand0;
   pm_t cand1;

   // Metrics never exceed 48, so the 6-bit sum cannot wrap
   assign cand0  = pm0 + pm_t'(bm0);
   assign cand1  = pm1 + pm_t'(bm1);
   assign dec    = (cand1 < cand0);
   assign pm_new = dec ? cand1 : cand0;

endmodule

// File: rtl/viterbi_decoder_top.sv
// Full-block Viterbi decoder: unrolled 8-step trellis of ACS cells, traceback, and output registers.
// Define VITERBI_PM_OUT_EN to also register the winning path metric on best_metric.
module viterbi_decoder_top
   import viterbi_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   viterbi_if.slave bus
);

   pm_t   pm   [NUM_STEPS+1][NUM_STATES];
   surv_t surv [NUM_STEPS];

   state_t               best_state;
   logic [NUM_STEPS-1:0] decoded;
   logic [NUM_STEPS-1:0] data_out_p0;

   // Only state 00 is a legal start; the others begin at "infinity"
   assign pm[0][0] = '0;
   assign pm[0][1] = PM_INF;
   assign pm[0][2] = PM_INF;
   assign pm[0][3] = PM_INF;

   for (genvar t = 0; t < NUM_STEPS; t++) begin : g_step
      logic [1:0] rx;
      logic       dec [NUM_STATES];

      assign rx = bus.data_in[IN_W-1-2*t -: 2];

      for (genvar n = 0; n < NUM_STATES; n++) begin : g_state
         localparam int U  = n / 2;
         localparam int A  = n % 2;
         localparam int P0 = 2 * A;
         localparam int P1 = 2 * A + 1;

         logic [1:0] bm0;
         logic [1:0] bm1;

         assign bm0 = hamming2(rx, branch_out(1'(U), state_t'(P0)));
         assign bm1 = hamming2(rx, branch_out(1'(U), state_t'(P1)));

         viterbi_acs u_acs (
            .pm0    (pm[t][P0]),
            .pm1    (pm[t][P1]),
            .bm0    (bm0),
            .bm1    (bm1),
            .pm_new (pm[t+1][n]),
            .dec    (dec[n])
         );
      end

      assign surv[t] = {dec[3], dec[2], dec[1], dec[0]};
   end

   always_comb begin
      pm_t best_pm;
      best_state = '0;
      best_pm    = pm[NUM_STEPS][0];
      // Strict compare keeps the lowest state index on a tie
      for (int s = 1; s < NUM_STATES; s++) begin
         if (pm[NUM_STEPS][s] < best_pm) begin
            best_pm    = pm[NUM_STEPS][s];
            best_state = state_t'(s);
         end
      end
   end

   always_comb begin
      state_t st;
      decoded = '0;
      st      = best_state;
      // State {u,a} came from {a, survivor}; its MSB is the bit decided at that step
      for (int t = NUM_STEPS - 1; t >= 0; t--) begin
         decoded[NUM_STEPS-1-t] = st[1];
         st = {st[0], surv[t][st]};
      end
   end

   // ---- stage 0 -> output register ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_p0 <= '0;
      end else begin
         data_out_p0 <= decoded;
      end
   end

   assign bus.data_out = data_out_p0;

`ifdef VITERBI_PM_OUT_EN
   pm_t best_metric_p0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         best_metric_p0 <= '0;
      end else begin
         best_metric_p0 <= pm[NUM_STEPS][best_state];
      end
   end

   assign bus.best_metric = best_metric_p0;
`endif

endmodule

// File: tb/tb_viterbi_decoder_top.sv
// Directed + random bench for viterbi_decoder_top with an expected-result queue and a
// brute-force maximum-likelihood reference (all 256 codewords).
module tb_viterbi_decoder_top;

   logic clk = 1'b0;
   logic rst = 1'b1;

   viterbi_if bus ();

   viterbi_decoder_top dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] din;
      logic [7:0]  exp_out;
      bit          exact;
   } item_t;

   item_t sb[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [15:0] encode(input logic [7:0] w);
      logic [15:0] c;
      logic u, u1, u2;
      u1 = 1'b0;
      u2 = 1'b0;
      c  = '0;
      for (int t = 0; t < 8; t++) begin
         u = w[7-t];
         c[15-2*t] = u;
         c[14-2*t] = u ^ u1 ^ u2;
         u2 = u1;
         u1 = u;
      end
      return c;
   endfunction

   function automatic int min_dist(input logic [15:0] rx);
      int best;
      int d;
      best = 99;
      for (int w = 0; w < 256; w++) begin
         d = $countones(encode(8'(w)) ^ rx);
         if (d < best) best = d;
      end
      return best;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic collect();
      item_t it;
      int md;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
         return;
      end
      it = sb.pop_front();
      md = min_dist(it.din);
      if (it.exact) check("data_out", 16'(bus.data_out), 16'(it.exp_out));
      check("ml_dist", 16'($countones(encode(bus.data_out) ^ it.din)), 16'(md));
`ifdef VITERBI_PM_OUT_EN
      check("best_metric", 16'(bus.best_metric), 16'(md));
`endif
   endtask

   task automatic step(input logic [15:0] din, input bit exact, input logic [7:0] expv);
      item_t it;
      bus.data_in = din;
      it.din      = din;
      it.exact    = exact;
      it.exp_out  = expv;
      sb.push_back(it);
      @(posedge clk);
      #1;
      collect();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.data_in = 16'hFFFF;
      #1 rst = 1'b0;
      #1;
      check("reset_async", 16'(bus.data_out), 16'h0000);
`ifdef VITERBI_PM_OUT_EN
      check("reset_pm", 16'(bus.best_metric), 16'h0000);
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", 16'(bus.data_out), 16'h0000);
      @(negedge clk);
      rst = 1'b1;

      step(16'hFFFF, 1'b1, 8'hFF);
      step(16'h0000, 1'b1, 8'h00);
      step(16'hD976, 1'b1, 8'hA5);
      step(16'h9976, 1'b1, 8'hA5);
      step(encode(8'h3C), 1'b1, 8'h3C);
      step(encode(8'h80), 1'b1, 8'h80);
      step(encode(8'h01), 1'b1, 8'h01);

      for (int i = 0; i < 24; i++) begin
         step(16'($urandom), 1'b0, 8'h00);
      end

      // Drop reset between edges during back-to-back traffic
      step(16'h0000, 1'b1, 8'h00);
      step(16'hD976, 1'b1, 8'hA5);
      #3 rst = 1'b0;
      #1;
      check("midstream_rst", 16'(bus.data_out), 16'h0000);
      bus.data_in = 16'h9976;
      @(posedge clk);
      #1;
      check("midstream_hold", 16'(bus.data_out), 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      step(16'h9976, 1'b1, 8'hA5);
      step(16'hFFFF, 1'b1, 8'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/viterbi_decoder_top.md
# viterbi_decoder_top

Hard-decision Viterbi decoder for a rate-1/2, constraint-length-3 systematic convolutional code. Each clock it decodes one 16-bit block of 8 received symbol pairs into 8 data bits and registers the result. The block sits at the receive end of the link after symbol slicing. Every block is decoded independently; no state carries over between blocks.

## Interface
- Parameters: none. All sizes are fixed constants in `viterbi_pkg`.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data_in`  in  16  received block; pair t = `data_in[15-2t : 14-2t]` = {c0, c1}, t = 0 (first) .. 7.
- `data_out`  out  8  decoded bits, registered; `data_out[7-t]` = u_t.
- `best_metric`  out  6  final winning path metric, registered. Present only with `VITERBI_PM_OUT_EN`.

## Operation
- Code definition:
  - encoder state s = {u_{t-1}, u_{t-2}}; start state 00.
  - c0 = u_t (systematic); c1 = u_t ^ u_{t-1} ^ u_{t-2}.
  - next state = {u_t, u_{t-1}}.
  - no tail/termination bits.
- Branch metric: Hamming distance (0..2) between the received pair and the branch output.
- Path metrics:
  - 6-bit unsigned, 4 states.
  - initial PM: state 0 = 0; states 1..3 = 32 (infinity).
  - max reachable value 48, so no saturation or normalisation is needed.
- ACS for each step t = 0..7 and each next state n = {u, a}:
  - predecessors are {a,0} and {a,1}.
  - candidate = PM(pred) + BM.
  - select the smaller; on a tie, select pred {a,0}.
  - store 1 survivor bit (selected pred LSB).
- Final state = minimum PM after step 7; on a tie, the lowest state index wins.
- Traceback from the final state over 8 steps: u_t = MSB of the state at step t+1.
- Decode is purely combinational from `data_in`. The result is captured into the output registers every rising edge; there is no handshake and no enable.

## Timing
- Latency is 1 cycle: `data_in` stable before rising edge k gives the matching `data_out` valid just after edge k. It is held until the next edge.
- New block accepted every cycle (throughput 1 block/cycle).
- Reset:
  - `rst` low forces `data_out` = 8'h00 and `best_metric` = 0 immediately, independent of `clk`.
  - outputs stay at reset values while `rst` is low.
  - first decode on the first rising edge after `rst` goes high.
- Reset asserted mid-stream discards the in-flight result; there is no recovery state.

## Configuration
- `VITERBI_PM_OUT_EN` defined:
  - `best_metric` port and its register exist.
  - `best_metric` is loaded with the final winning PM on the same edge as `data_out`.
- Undefined: the port and register are absent; `data_out` behaviour is identical.

## Structure
- `viterbi_pkg`:
  - NUM_STATES=4, NUM_STEPS=8, PM_W=6, PM_INF=32.
  - generator masks G0=3'b100, G1=3'b111.
  - typedefs for state index, path metric and survivor vector.
- Sub-module `viterbi_acs`: one add-compare-select unit (2 PMs + 2 BMs in; new PM + decision bit out). Replicated 4 states × 8 steps.
- Top contains branch-metric logic, traceback and output registers.

## Test plan
- Reset: hold `rst`=0 with any `data_in` → `data_out`=8'h00 (and `best_metric`=0), with no clock edge required.
- All ones: `data_in`=16'hFFFF → after 1 edge, `data_out`=8'hFF; `best_metric`=1.
- All zeros: 16'h0000 → 8'h00; `best_metric`=0.
- Clean codeword: 16'hD976 (encoding of 8'hA5) → 8'hA5; `best_metric`=0.
- Single error corrected: 16'h9976 (bit 14 flipped) → 8'hA5; `best_metric`=1.
- Async reset mid-stream: during back-to-back blocks, drop `rst` between edges → `data_out` goes to 00 at once. After release, the next edge shows the decode of the current `data_in`.
